// File: rtl/video_cursor_overlay.sv
// rtl/video_cursor_overlay.sv - XOR text-cursor overlay between character display and VGA DAC
//
// Re-derives pixel, line and character-cell position from the upstream sync
// edges. It XORs iCursorColor onto one character cell, limited to the glyph
// rows at or below CURSOR_TOP_ROW. Colour and sync leave together, one clock
// after they arrive.
//
// Optional feature macro: VIDEO_CURSOR_BLINK_EN
//   defined   - the cursor blinks with a period of 2*BLINK_FRAMES frames
//   undefined - the cursor is steady whenever it is enabled
//
// Ports:
//   iVideoClk     in   1  pixel clock
//   iRst          in   1  synchronous active-high reset
//   iColor        in   8  colour from character display
//   iHS, iVS      in   1  active-low syncs from character display
//   iCursorEn     in   1  cursor enable (sampled on VS rise)
//   iCursorCol    in   7  cursor column (sampled on VS rise)
//   iCursorRow    in   6  cursor row (sampled on VS rise)
//   iCursorColor  in   8  XOR mask applied inside the cursor (live)
//   oColor        out  8  colour to DAC
//   oHS, oVS      out  1  syncs to DAC, delayed one clock

module video_cursor_overlay #(
  parameter int H_BACK_PORCH   = 47,
  parameter int V_BACK_PORCH   = 23,
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int CELL_W         = 8,
  parameter int CELL_H         = 12,
  parameter int CURSOR_TOP_ROW = 10,
  parameter int BLINK_FRAMES   = 16
) (
  input  logic       iVideoClk,
  input  logic       iRst,
  input  logic [7:0] iColor,
  input  logic       iHS,
  input  logic       iVS,
  input  logic       iCursorEn,
  input  logic [6:0] iCursorCol,
  input  logic [5:0] iCursorRow,
  input  logic [7:0] iCursorColor,
  output logic [7:0] oColor,
  output logic       oHS,
  output logic       oVS
);

  localparam int CELL_SHIFT = $clog2(CELL_W);
  localparam int GLYPH_W    = (CELL_H > 1) ? $clog2(CELL_H) : 1;

  localparam logic [9:0] H_START = 10'(H_BACK_PORCH);
  localparam logic [9:0] H_END   = 10'(H_BACK_PORCH + H_ACTIVE);
  localparam logic [9:0] V_START = 10'(V_BACK_PORCH);
  localparam logic [9:0] V_END   = 10'(V_BACK_PORCH + V_ACTIVE);
  localparam logic [9:0] CNT_MAX = 10'h3FF;

  // Columns and rows that exist on screen. A cursor outside this grid is
  // simply not drawn.
  localparam logic [6:0] NUM_COLS = 7'(H_ACTIVE / CELL_W);
  localparam logic [5:0] NUM_ROWS = 6'(V_ACTIVE / CELL_H);

  localparam logic [GLYPH_W-1:0] GLYPH_LAST = GLYPH_W'(CELL_H - 1);
  localparam logic [GLYPH_W-1:0] TOP_ROW    = GLYPH_W'(CURSOR_TOP_ROW);

  logic               hs_d, vs_d;
  logic               hs_rise, vs_rise;
  logic [9:0]         pix_q, pix;
  logic [9:0]         line_q, line;
  logic [GLYPH_W-1:0] glyph_q;
  logic [5:0]         cell_row_q;
  logic               sh_en;
  logic [6:0]         sh_col;
  logic [5:0]         sh_row;
  logic               blink_phase;
  logic               active;
  logic [9:0]         x_pos, cell_col;
  logic               hit;

  assign hs_rise = iHS & ~hs_d;
  assign vs_rise = iVS & ~vs_d;

  // pix and line are the position of the current cycle. The registered
  // copies hold the previous cycle's value. Both saturate, so a missing
  // sync stream cannot wrap around into the active window.
  always_comb begin
    pix = pix_q;
    if (hs_rise) begin
      pix = '0;
    end else if (pix_q != CNT_MAX) begin
      pix = pix_q + 10'd1;
    end
  end

  always_comb begin
    line = line_q;
    if (vs_rise) begin
      line = '0;
    end else if (hs_rise && line_q != CNT_MAX) begin
      line = line_q + 10'd1;
    end
  end

  assign active = (pix >= H_START) && (pix < H_END) &&
                  (line >= V_START) && (line < V_END);
  assign x_pos    = pix - H_START;
  assign cell_col = x_pos >> CELL_SHIFT;

  always_ff @(posedge iVideoClk) begin
    if (iRst) begin
      hs_d   <= 1'b1;
      vs_d   <= 1'b1;
      pix_q  <= '0;
      line_q <= '0;
    end else begin
      hs_d   <= iHS;
      vs_d   <= iVS;
      pix_q  <= pix;
      line_q <= line;
    end
  end

  // Glyph row and cell row are tracked incrementally on each HS rise, so no
  // divide-by-CELL_H is needed. The HS-rise cycle is never an active pixel,
  // which means the registered values are already settled for the line.
  always_ff @(posedge iVideoClk) begin
    if (iRst) begin
      glyph_q    <= '0;
      cell_row_q <= '0;
    end else if (hs_rise) begin
      if (line == V_START) begin
        glyph_q    <= '0;
        cell_row_q <= '0;
      end else if (line > V_START && line < V_END) begin
        if (glyph_q == GLYPH_LAST) begin
          glyph_q    <= '0;
          cell_row_q <= cell_row_q + 6'd1;
        end else begin
          glyph_q <= glyph_q + 1'b1;
        end
      end
    end
  end

  // Cursor position is latched once per frame, so the cursor cannot tear.
  // Reset clears the enable. Because the position is unknown after a reset,
  // the overlay stays off until the next VS rise re-anchors the counters.
  always_ff @(posedge iVideoClk) begin
    if (iRst) begin
      sh_en  <= 1'b0;
      sh_col <= '0;
      sh_row <= '0;
    end else if (vs_rise) begin
      sh_en  <= iCursorEn && (iCursorCol < NUM_COLS) && (iCursorRow < NUM_ROWS);
      sh_col <= iCursorCol;
      sh_row <= iCursorRow;
    end
  end

`ifdef VIDEO_CURSOR_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] frame_cnt;

  always_ff @(posedge iVideoClk) begin
    if (iRst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (vs_rise) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  assign blink_phase = 1'b1;
`endif

  assign hit = active && sh_en &&
               (cell_col == {3'd0, sh_col}) &&
               (cell_row_q == sh_row) &&
               (glyph_q >= TOP_ROW) &&
               blink_phase;

  // Colour and syncs share one register stage so they stay aligned at the DAC.
  always_ff @(posedge iVideoClk) begin
    if (iRst) begin
      oColor <= 8'h00;
      oHS    <= 1'b1;
      oVS    <= 1'b1;
    end else begin
      oColor <= hit ? (iColor ^ iCursorColor) : iColor;
      oHS    <= iHS;
      oVS    <= iVS;
    end
  end

endmodule
